// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: operation and FSM encodings, widths and helpers shared by the
// sequential multiply/divide unit.
package muldiv_seq_pkg;

    localparam int W     = 32;
    localparam int CNT_W = 5;

    typedef logic [W-1:0]   word_t;
    typedef logic [2*W-1:0] dword_t;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;
    localparam logic [CNT_W-1:0] CNT_INC  = 5'd1;

    // Magnitude of a two's-complement word; 0x80000000 maps to itself, which
    // is its correct unsigned magnitude.
    function automatic word_t mag(input word_t v, input logic sgn);
        return (sgn && v[W-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration -- shift-add multiply or, with
// MULDIV_DIV_EN defined, restoring-divide subtract-and-shift selected by div_i.
module muldiv_step
    import muldiv_seq_pkg::*;
(
`ifdef MULDIV_DIV_EN
    input  logic  div_i,
`endif
    input  word_t hi_i,
    input  word_t lo_i,
    input  word_t m_i,
    output word_t hi_o,
    output word_t lo_o
);

    logic [W:0] sum;

    assign sum = (W+1)'(hi_i) + (W+1)'(lo_i[0] ? m_i : '0);

`ifdef MULDIV_DIV_EN
    logic [W:0] sh;
    logic       ok;
    word_t      diff;

    // The partial remainder is always below the divisor, so the difference fits W bits.
    assign sh   = {hi_i, lo_i[W-1]};
    assign ok   = sh >= (W+1)'(m_i);
    assign diff = sh[W-1:0] - m_i;
    assign hi_o = div_i ? (ok ? diff : sh[W-1:0]) : sum[W:1];
    assign lo_o = div_i ? {lo_i[W-2:0], ok} : {sum[0], lo_i[W-1:1]};
`else
    assign hi_o = sum[W:1];
    assign lo_o = {sum[0], lo_i[W-1:1]};
`endif

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: 32-iteration sequential MULT/MULTU/DIV/DIVU unit with HI/LO.
// Divide support is built only when MULDIV_DIV_EN is defined.
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         flush,
    input  logic         hi_we,
    input  logic         lo_we,
    input  logic [W-1:0] wdata,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         div_by_zero
);

    logic [2:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    word_t            a_q, a_d, b_q, b_d, m_q, m_d;
    word_t            wh_q, wh_d, wl_q, wl_d;
    word_t            hi_q, hi_d, lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d, dbz_q, dbz_d;
    logic             is_signed;
    dword_t           prod_fix;
    word_t            step_hi, step_lo;

    assign is_signed = op_q == MD_MULT || op_q == MD_DIV;
    assign prod_fix  = neg_q ? -{wh_q, wl_q} : {wh_q, wl_q};

`ifdef MULDIV_DIV_EN
    logic rneg_q, rneg_d;
    logic is_div;

    assign is_div = op_q == MD_DIV || op_q == MD_DIVU;
`else
    logic is_div_in;

    assign is_div_in = op == MD_DIV || op == MD_DIVU;
`endif

    muldiv_step u_step (
`ifdef MULDIV_DIV_EN
        .div_i (is_div),
`endif
        .hi_i  (wh_q),
        .lo_i  (wl_q),
        .m_i   (m_q),
        .hi_o  (step_hi),
        .lo_o  (step_lo)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        wh_d    = wh_q;
        wl_d    = wl_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        dbz_d   = dbz_q;
`ifdef MULDIV_DIV_EN
        rneg_d  = rneg_q;
`endif
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    hi_d = hi_we ? wdata : hi_q;
                    lo_d = lo_we ? wdata : lo_q;
`ifdef MULDIV_DIV_EN
                    state_d = start ? S_PREP : S_IDLE;
`else
                    // Without the divide datapath a divide completes immediately.
                    state_d = start ? (is_div_in ? S_DONE : S_PREP) : S_IDLE;
`endif
                    op_d  = start ? op : op_q;
                    a_d   = start ? a : a_q;
                    b_d   = start ? b : b_q;
                    dbz_d = start ? '0 : dbz_q;
                end
                S_PREP: begin
                    neg_d   = is_signed && (a_q[W-1] ^ b_q[W-1]);
                    wh_d    = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
`ifdef MULDIV_DIV_EN
                    rneg_d = is_signed && a_q[W-1];
                    m_d    = mag(is_div ? b_q : a_q, is_signed);
                    wl_d   = mag(is_div ? a_q : b_q, is_signed);
                    if (is_div && b_q == '0) begin
                        hi_d    = a_q;
                        lo_d    = '1;
                        dbz_d   = '1;
                        state_d = S_DONE;
                    end
`else
                    m_d  = mag(a_q, is_signed);
                    wl_d = mag(b_q, is_signed);
`endif
                end
                S_RUN: begin
                    wh_d    = step_hi;
                    wl_d    = step_lo;
                    cnt_d   = cnt_q + CNT_INC;
                    state_d = cnt_q == CNT_LAST ? S_FIX : S_RUN;
                end
                S_FIX: begin
`ifdef MULDIV_DIV_EN
                    if (is_div) begin
                        lo_d = neg_q ? -wl_q : wl_q;
                        hi_d = rneg_q ? -wh_q : wh_q;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
`else
                    {hi_d, lo_d} = prod_fix;
`endif
                    state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            wh_q    <= '0;
            wl_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= '0;
            dbz_q   <= '0;
`ifdef MULDIV_DIV_EN
            rneg_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            wh_q    <= wh_d;
            wl_q    <= wl_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            dbz_q   <= dbz_d;
`ifdef MULDIV_DIV_EN
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign busy        = state_q == S_PREP || state_q == S_RUN || state_q == S_FIX;
    assign done        = state_q == S_DONE;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-003 SHALL have port start, input, 1, request to launch an operation.
REQ-004 SHALL have port op, input, 2, operation select (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU).
REQ-005 SHALL have port a, input, 32, rs operand (multiplicand/dividend).
REQ-006 SHALL have port b, input, 32, rt operand (multiplier/divisor).
REQ-007 SHALL have port flush, input, 1, abort in-flight operation.
REQ-008 SHALL have ports hi_we and lo_we, input, 1 each, plus wdata, input, 32; these implement MTHI and MTLO.
REQ-009 SHALL have port busy, output, 1, operation in flight; the pipeline stalls on it.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have ports hi and lo, output, 32 each, architectural HI/LO.
REQ-012 SHALL have port div_by_zero, output, 1, valid with done.

Function
REQ-013 SHALL use FSM states IDLE, PREP, RUN, FIX and DONE; DONE returns to IDLE unless start is accepted.
REQ-014 SHALL accept start only in IDLE or DONE; start in other states SHALL be ignored.
REQ-015 Accept at cycle T SHALL give: PREP at T+1 (operand magnitudes and result sign captured), RUN at T+2..T+33 (exactly 32 iterations on a 5-bit counter), FIX at T+34 (sign applied, HI/LO written), DONE at T+35.
REQ-016 busy SHALL be high in PREP, RUN and FIX, and low in IDLE and DONE.
REQ-017 done SHALL be high only in DONE; hi/lo SHALL already hold the new result in that cycle.
REQ-018 Multiply SHALL use shift-add producing a 64-bit product, with HI = product[63:32] and LO = product[31:0]. MULT is signed; MULTU is unsigned.
REQ-019 Divide SHALL use a restoring algorithm with LO = quotient and HI = remainder. Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF SHALL yield LO = 0x80000000 and HI = 0, with no error flag.
REQ-021 DIV/DIVU with b = 0 SHALL go PREP->DONE, skipping RUN and FIX, so done is at T+2. Result: HI = a, LO = 0xFFFFFFFF, div_by_zero = 1.
REQ-022 div_by_zero SHALL be low in every other case and SHALL hold its value until the next accept.
REQ-023 flush SHALL force IDLE on the next edge. It SHALL leave HI/LO unchanged and produce no done.
REQ-024 flush and start in the same cycle: flush wins and start is dropped.
REQ-025 hi_we/lo_we SHALL write wdata in IDLE or DONE. They SHALL be ignored while busy.
REQ-026 If hi_we/lo_we coincide with an accepted start, the write SHALL occur and the operation result SHALL overwrite it later.

Reset
REQ-027 With rst_n low at an edge, the block SHALL set state = IDLE, hi = lo = 0, busy = done = div_by_zero = 0, and counter and working registers to 0.
REQ-028 Reset mid-operation SHALL abort it with no done pulse. Reset SHALL have priority over flush, start and hi_we/lo_we.

Configuration
REQ-029 Macro MULDIV_DIV_EN defined: divide is supported as in REQ-019..REQ-021.
REQ-030 MULDIV_DIV_EN undefined: the divide datapath SHALL be absent. DIV/DIVU accepted at T SHALL give done at T+1, busy never high, HI/LO unchanged, div_by_zero = 0.

Structure
REQ-031 SHALL define the op encodings MD_MULT = 0, MD_MULTU = 1, MD_DIV = 2, MD_DIVU = 3 and the FSM state encodings in the shared const.v. No literals SHALL appear in the module.
REQ-032 SHALL instantiate one sub-module, muldiv_step: combinational 33-bit add/subtract-and-shift for one iteration, selected by a mode bit. All registers SHALL stay in muldiv_seq.

Verification
REQ-033 MULTU 0xFFFFFFFF x 0xFFFFFFFF at T -> done at T+35, HI = 0xFFFFFFFE, LO = 0x00000001, busy high T+1..T+34.
REQ-034 MULT 0xFFFFFFFD x 0x00000007 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
REQ-035 DIV 0xFFFFFFF9 / 0x00000002 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
REQ-036 DIVU 0x00001234 / 0 at T -> done at T+2, div_by_zero = 1, HI = 0x00001234, LO = 0xFFFFFFFF.
REQ-037 Preload HI = 0xAAAA0000 via hi_we, start MULTU, then flush at T+10 -> IDLE at T+11, no done, HI = 0xAAAA0000; retry with rst_n low at T+10 -> hi = lo = 0 next cycle.
REQ-038 start during RUN and hi_we during RUN -> both ignored, the original result is delivered unchanged at T+35; back-to-back start in DONE -> second done at T+70.
